spi_master_port: RTL and testbench



---
 rtl/epga_spi_pkg.sv | 29 ++
 rtl/spi_phase_tick.sv | 40 ++++
 rtl/spi_master_port.sv | 171 +++++++++++++++++
 tb/tb_spi_master_port.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/epga_spi_pkg.sv
// Shared definitions for the synthesizer SPI master ports: state encoding,
// transfer direction codes and frame width limit.
package epga_spi_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SCK_HIGH = 3'd2;
  localparam logic [2:0] ST_SCK_LOW  = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    SETUP    = ST_SETUP,
    SCK_HIGH = ST_SCK_HIGH,
    SCK_LOW  = ST_SCK_LOW,
    GAP      = ST_GAP
  } spi_state_e;

  localparam logic SPI_DIR_WRITE = 1'b0;
  localparam logic SPI_DIR_READ  = 1'b1;

  localparam int SPI_MAX_BITS = 24;

  // Requests wider than the port are truncated to the port width.
  function automatic logic [7:0] clampDepth(input logic [7:0] depth, input logic [7:0] maxBits);
    return (depth > maxBits) ? maxBits : depth;
  endfunction

endpackage

// File: rtl/spi_phase_tick.sv
// Down-counter shared by SCLK half-period and chip-select gap timing; tick_o
// is high once the loaded interval has fully elapsed.
module spi_phase_tick #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic gap_i,
  output logic tick_o
);

  localparam int MaxCount = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CntW     = $clog2(MaxCount) + 1;
  localparam logic [CntW-1:0] DivLoad = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLoad = CntW'(CS_GAP - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = gap_i ? GapLoad : DivLoad;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == '0);

endmodule

// File: rtl/spi_master_port.sv
// SPI mode 0 master for one synthesizer device: one MSB-first frame per
// accepted request, optional MISO capture, cs_n rising edge latches the device.
module spi_master_port
  import epga_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_GAP   = 4,
  parameter int MAX_BITS = SPI_MAX_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spi_start,
  input  logic                spi_dir,
  input  logic [MAX_BITS-1:0] spi_data_tx,
  input  logic [7:0]          spi_data_depth,
  output logic                spi_ready,
  output logic [MAX_BITS-1:0] spi_data_rx,
  output logic                rx_valid,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic                cs_n
);

  localparam logic [7:0] MaxBits8 = 8'(MAX_BITS);

  spi_state_e          state_q, state_d;
  logic [MAX_BITS-1:0] txShift_q, txShift_d;
  logic [MAX_BITS-1:0] rxShift_q, rxShift_d;
  logic [MAX_BITS-1:0] rxData_q, rxData_d;
  logic [7:0]          bitsLeft_q, bitsLeft_d;
  logic                dir_q, dir_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                csN_q, csN_d;
  logic                ready_q, ready_d;
  logic                rxValid_q, rxValid_d;

  logic                tick, tickLoad, tickGap;
  logic [7:0]          depthEff;
  logic [MAX_BITS-1:0] alignedTx;
  logic [MAX_BITS-1:0] captured;

  spi_phase_tick #(
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) u_phase_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(tickLoad),
    .gap_i (tickGap),
    .tick_o(tick)
  );

  // Frame data is left-aligned so the next MOSI bit is always the shifter MSB.
  assign depthEff  = clampDepth(spi_data_depth, MaxBits8);
  assign alignedTx = spi_data_tx << (MaxBits8 - depthEff);
  assign captured  = {rxShift_q[MAX_BITS-2:0], miso};

  always_comb begin
    state_d    = state_q;
    txShift_d  = txShift_q;
    rxShift_d  = rxShift_q;
    rxData_d   = rxData_q;
    bitsLeft_d = bitsLeft_q;
    dir_d      = dir_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    csN_d      = csN_q;
    ready_d    = ready_q;
    rxValid_d  = 1'b0;
    tickLoad   = 1'b0;
    tickGap    = 1'b0;

    case (state_q)
      IDLE: begin
        if (spi_start && depthEff != 8'd0) begin
          state_d    = SETUP;
          txShift_d  = alignedTx;
          rxShift_d  = '0;
          bitsLeft_d = depthEff;
          dir_d      = spi_dir;
          mosi_d     = alignedTx[MAX_BITS-1];
          csN_d      = 1'b0;
          ready_d    = 1'b0;
          tickLoad   = 1'b1;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d  = SCK_HIGH;
          sclk_d   = 1'b1;
          tickLoad = 1'b1;
          if (dir_q == SPI_DIR_READ) rxShift_d = captured;
        end
      end
      SCK_HIGH: begin
        if (tick) begin
          state_d    = SCK_LOW;
          sclk_d     = 1'b0;
          txShift_d  = txShift_q << 1;
          mosi_d     = txShift_q[MAX_BITS-2];
          bitsLeft_d = bitsLeft_q - 8'd1;
          tickLoad   = 1'b1;
        end
      end
      SCK_LOW: begin
        if (tick) begin
          tickLoad = 1'b1;
          if (bitsLeft_q == 8'd0) begin
            state_d = GAP;
            csN_d   = 1'b1;
            mosi_d  = 1'b0;
            tickGap = 1'b1;
            if (dir_q == SPI_DIR_READ) begin
              rxData_d  = rxShift_q;
              rxValid_d = 1'b1;
            end
          end else begin
            state_d = SCK_HIGH;
            sclk_d  = 1'b1;
            if (dir_q == SPI_DIR_READ) rxShift_d = captured;
          end
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      txShift_q  <= '0;
      rxShift_q  <= '0;
      rxData_q   <= '0;
      bitsLeft_q <= 8'd0;
      dir_q      <= SPI_DIR_WRITE;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      csN_q      <= 1'b1;
      ready_q    <= 1'b1;
      rxValid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      txShift_q  <= txShift_d;
      rxShift_q  <= rxShift_d;
      rxData_q   <= rxData_d;
      bitsLeft_q <= bitsLeft_d;
      dir_q      <= dir_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      csN_q      <= csN_d;
      ready_q    <= ready_d;
      rxValid_q  <= rxValid_d;
    end
  end

  assign spi_ready   = ready_q;
  assign spi_data_rx = rxData_q;
  assign rx_valid    = rxValid_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs_n        = csN_q;

endmodule

// File: tb/tb_spi_master_port.sv
// Randomized bench for two spi_master_port instances (slow and fast timing);
// a pin-level monitor records each frame and is compared with the frame rules.
module tb_spi_master_port;

  logic clk = 1'b0;
  logic rst_n;
  logic spiStart[2], spiDir[2], spiReady[2], rxValid[2];
  logic sclk[2], mosi[2], miso[2], csN[2];
  logic [23:0] spiDataTx[2], spiDataRx[2];
  logic [7:0]  spiDataDepth[2];

  int testsRun = 0, testsFailed = 0;

  // monitor state and per-frame records, indexed by frame number mod 256
  int frCnt[2], csLowRun[2], rdyLowRun[2], csHighRun[2], rdyHighRun[2];
  int curRises[2], rxPulses[2], rxDouble[2], misoDepth[2], misoIdx[2];
  logic [31:0] curMosi[2], misoWord[2];
  logic prevCs[2], prevSclk[2], prevRdy[2], prevRxV[2];
  int recCsLow[2][256], recRdyLow[2][256], recRises[2][256], recCsHigh[2][256], recRdyHigh[2][256];
  logic [31:0] recMosi[2][256];
  logic recRxAtRise[2][256];
  logic [23:0] lastRx[2];

  always #5 clk = ~clk;

  spi_master_port #(.CLK_DIV(4), .CS_GAP(4), .MAX_BITS(24)) dut0 (
    .clk(clk), .rst_n(rst_n), .spi_start(spiStart[0]), .spi_dir(spiDir[0]),
    .spi_data_tx(spiDataTx[0]), .spi_data_depth(spiDataDepth[0]), .spi_ready(spiReady[0]),
    .spi_data_rx(spiDataRx[0]), .rx_valid(rxValid[0]), .sclk(sclk[0]), .mosi(mosi[0]),
    .miso(miso[0]), .cs_n(csN[0]));

  spi_master_port #(.CLK_DIV(1), .CS_GAP(1), .MAX_BITS(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi_start(spiStart[1]), .spi_dir(spiDir[1]),
    .spi_data_tx(spiDataTx[1]), .spi_data_depth(spiDataDepth[1]), .spi_ready(spiReady[1]),
    .spi_data_rx(spiDataRx[1]), .rx_valid(rxValid[1]), .sclk(sclk[1]), .mosi(mosi[1]),
    .miso(miso[1]), .cs_n(csN[1]));

  function automatic int clkDivOf(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  function automatic int csGapOf(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  function automatic logic [23:0] maskOf(input int d);
    logic [24:0] one;
    one = 25'd1;
    return 24'((one << d) - 25'd1);
  endfunction

  // Pin-level monitor: also plays the MISO device, changing data after sclk falls.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        csLowRun[g] = 0; rdyLowRun[g] = 0; csHighRun[g] = 0; rdyHighRun[g] = 0;
        curRises[g] = 0; curMosi[g] = 0; miso[g] = 1'b0;
        prevCs[g] = 1'b1; prevSclk[g] = 1'b0; prevRdy[g] = 1'b1; prevRxV[g] = 1'b0;
      end else begin
        if (rxValid[g] === 1'b1) begin
          rxPulses[g]++;
          if (prevRxV[g]) rxDouble[g]++;
        end
        if (sclk[g] && !prevSclk[g]) begin
          curRises[g]++;
          curMosi[g] = {curMosi[g][30:0], mosi[g]};
        end
        if (!csN[g] && prevCs[g]) begin
          recCsHigh[g][frCnt[g] % 256] = csHighRun[g];
          csHighRun[g] = 0;
          misoIdx[g] = misoDepth[g] - 1;
          miso[g] = misoWord[g][misoIdx[g]];
        end else if (!sclk[g] && prevSclk[g] && !csN[g]) begin
          misoIdx[g]--;
          if (misoIdx[g] >= 0) miso[g] = misoWord[g][misoIdx[g]];
        end
        if (!spiReady[g] && prevRdy[g]) begin
          recRdyHigh[g][frCnt[g] % 256] = rdyHighRun[g];
          rdyHighRun[g] = 0;
        end
        if (csN[g] && !prevCs[g]) begin
          recCsLow[g][frCnt[g] % 256]    = csLowRun[g];
          recRises[g][frCnt[g] % 256]    = curRises[g];
          recMosi[g][frCnt[g] % 256]     = curMosi[g];
          recRxAtRise[g][frCnt[g] % 256] = rxValid[g];
          frCnt[g]++;
          csLowRun[g] = 0; curRises[g] = 0; curMosi[g] = 0;
        end
        if (spiReady[g] && !prevRdy[g]) begin
          recRdyLow[g][(frCnt[g] - 1) % 256] = rdyLowRun[g];
          rdyLowRun[g] = 0;
        end
        if (!csN[g]) csLowRun[g]++; else csHighRun[g]++;
        if (!spiReady[g]) rdyLowRun[g]++; else rdyHighRun[g]++;
        prevCs[g] = csN[g]; prevSclk[g] = sclk[g]; prevRdy[g] = spiReady[g]; prevRxV[g] = rxValid[g];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitReady(input int g, input logic level, input int budget);
    int n;
    n = 0;
    while (spiReady[g] !== level && n < budget) begin
      stepCycle();
      n++;
    end
  endtask

  // One request; frame shape and data are derived from the request alone.
  task automatic applyStimulus(input int g, input logic [23:0] data, input logic [7:0] depth,
                               input logic dir, input logic [23:0] misoVal);
    int d, base, idx, pulses0, n;
    d = (depth > 8'd24) ? 24 : int'(depth);
    stepCycle();
    misoWord[g] = {8'h0, misoVal};
    misoDepth[g] = d;
    spiDataTx[g] = data; spiDataDepth[g] = depth; spiDir[g] = dir; spiStart[g] = 1'b1;
    base = frCnt[g];
    pulses0 = rxPulses[g];
    waitReady(g, 1'b0, 20);
    checkOutput("accept", spiReady[g], 0);
    spiStart[g] = 1'b0;
    spiDataTx[g] = 24'($urandom); spiDataDepth[g] = 8'($urandom); spiDir[g] = 1'($urandom);
    n = 0;
    while (!(frCnt[g] == base + 1 && spiReady[g] === 1'b1) && n < 3000) begin
      stepCycle();
      n++;
    end
    idx = base % 256;
    checkOutput("done", spiReady[g], 1);
    checkOutput("csLowCycles", recCsLow[g][idx], clkDivOf(g) * (2 * d + 1));
    checkOutput("readyLowCycles", recRdyLow[g][idx], clkDivOf(g) * (2 * d + 1) + csGapOf(g));
    checkOutput("sclkRises", recRises[g][idx], d);
    checkOutput("mosiBits", recMosi[g][idx], {8'h0, data & maskOf(d)});
    checkOutput("rxValidAtCsRise", recRxAtRise[g][idx], dir);
    checkOutput("rxValidPulses", rxPulses[g] - pulses0, dir);
    if (dir) lastRx[g] = misoVal & maskOf(d);
    checkOutput("rxData", spiDataRx[g], lastRx[g]);
  endtask

  task automatic backToBack(input int d);
    logic [23:0] words[5];
    int base;
    for (int k = 0; k < 5; k++) words[k] = 24'($urandom);
    stepCycle();
    base = frCnt[0];
    spiDataTx[0] = words[0]; spiDataDepth[0] = 8'(d); spiDir[0] = 1'b0; spiStart[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waitReady(0, 1'b0, 20);
      checkOutput("b2bAccept", spiReady[0], 0);
      if (k == 4) spiStart[0] = 1'b0;
      waitReady(0, 1'b1, 1000);
      checkOutput("b2bDone", spiReady[0], 1);
      if (k < 4) spiDataTx[0] = words[k + 1];
    end
    stepCycle();
    for (int k = 0; k < 5; k++) begin
      checkOutput("b2bMosi", recMosi[0][(base + k) % 256], {8'h0, words[k] & maskOf(d)});
      if (k > 0) begin
        // cs_n stays high through the gap plus the single ready cycle
        checkOutput("b2bCsHigh", recCsHigh[0][(base + k) % 256], csGapOf(0) + 1);
        checkOutput("b2bReadyHigh", recRdyHigh[0][(base + k) % 256], 1);
      end
    end
  endtask

  initial begin
    int f0, p0, n;
    for (int g = 0; g < 2; g++) begin
      spiStart[g] = 1'b0; spiDir[g] = 1'b0; spiDataTx[g] = '0; spiDataDepth[g] = '0;
      misoWord[g] = '0; misoDepth[g] = 1; lastRx[g] = '0;
      frCnt[g] = 0; rxPulses[g] = 0; rxDouble[g] = 0;
    end
    rst_n = 1'b0;
    #22;
    checkOutput("resetSclk", sclk[0], 0);
    checkOutput("resetMosi", mosi[0], 0);
    checkOutput("resetCsN", csN[0], 1);
    checkOutput("resetReady", spiReady[0], 1);
    checkOutput("resetRxValid", rxValid[0], 0);
    checkOutput("resetRxData", spiDataRx[0], 0);
    checkOutput("resetReady1", spiReady[1], 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) stepCycle();

    applyStimulus(0, 24'h1F8093, 8'd24, 1'b0, 24'h0);
    applyStimulus(0, 24'h123456, 8'd24, 1'b1, 24'hA5C3F0);
    applyStimulus(0, 24'h00FFFF, 8'd8, 1'b0, 24'h0);
    checkOutput("rxHoldAfterWrite", spiDataRx[0], 24'hA5C3F0);
    applyStimulus(1, 24'h00003C, 8'd8, 1'b0, 24'h0);

    // depth 0 request must be ignored
    f0 = frCnt[0];
    spiDataDepth[0] = 8'd0; spiStart[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      stepCycle();
      if (csN[0] !== 1'b1 || spiReady[0] !== 1'b1) n++;
    end
    spiStart[0] = 1'b0;
    checkOutput("depth0Idle", n, 0);
    checkOutput("depth0Rises", curRises[0], 0);
    checkOutput("depth0Frames", frCnt[0], f0);

    applyStimulus(0, 24'($urandom), 8'd30, 1'b0, 24'h0);
    applyStimulus(1, 24'($urandom), 8'd200, 1'b1, 24'($urandom));

    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < 2; g++) begin
        applyStimulus(g, 24'($urandom), 8'($urandom_range(1, 28)), 1'($urandom), 24'($urandom));
      end
    end

    backToBack(12);

    // reset mid-frame after 10 bits
    stepCycle();
    f0 = frCnt[0]; p0 = rxPulses[0];
    misoWord[0] = 32'hFFFFFF; misoDepth[0] = 24;
    spiDataTx[0] = 24'($urandom); spiDataDepth[0] = 8'd24; spiDir[0] = 1'b1; spiStart[0] = 1'b1;
    waitReady(0, 1'b0, 20);
    spiStart[0] = 1'b0;
    n = 0;
    while (curRises[0] < 10 && n < 1000) begin
      stepCycle();
      n++;
    end
    checkOutput("midResetBits", curRises[0], 10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetCsN", csN[0], 1);
    checkOutput("midResetSclk", sclk[0], 0);
    repeat (3) stepCycle();
    rst_n = 1'b1;
    repeat (2) stepCycle();
    checkOutput("midResetRxPulses", rxPulses[0] - p0, 0);
    checkOutput("midResetRxData", spiDataRx[0], 0);
    checkOutput("midResetFrames", frCnt[0], f0);
    lastRx[0] = '0; lastRx[1] = '0;
    applyStimulus(0, 24'($urandom), 8'd24, 1'b1, 24'($urandom));
    applyStimulus(1, 24'($urandom), 8'd16, 1'b1, 24'($urandom));

    checkOutput("rxValidWidth", rxDouble[0] + rxDouble[1], 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
